cms_pix28_err_collector: RTL and testbench

Verification-side error collector sitting directly downstream of the bench checkers. Each checker raises a one-cycle pulse on its assigned error index. The block keeps a sticky error bitmap and a saturating count per index. It also records the first error (index plus timestamp) and serves a request/acknowledge readout, so the end-of-test report and the live pass/fail monitor read from a single source.

---
 rtl/cms_pix28_err_collector_if.sv | 37 +++
 rtl/cms_pix28_err_collector.sv | 183 ++++++++++++++++++
 tb/tb_cms_pix28_err_collector.sv | 201 ++++++++++++++++++++
 3 files changed

// File: rtl/cms_pix28_err_collector_if.sv
// Error-collector bus: checker pulses, control pulses, readout handshake and
// the collected status outputs. The collector takes the slave side.
`timescale 1ns/1ps
interface cms_pix28_err_collector_if #(
  parameter int NUM_IDX = 32,
  parameter int CNT_W   = 8,
  parameter int TOT_W   = 16,
  parameter int TS_W    = 32
);
  logic [NUM_IDX-1:0] err_pulse_i;
  logic               arm_i;
  logic               freeze_i;
  logic               clr_i;
  logic               rd_req_i;
  logic [4:0]         rd_idx_i;
  logic               rd_ack_o;
  logic [CNT_W-1:0]   rd_cnt_o;
  logic [NUM_IDX-1:0] err_flags_o;
  logic               err_any_o;
  logic [TOT_W-1:0]   err_total_o;
  logic               first_vld_o;
  logic [4:0]         first_idx_o;
  logic [TS_W-1:0]    first_ts_o;
  logic [1:0]         state_o;

  modport master (
    output err_pulse_i, arm_i, freeze_i, clr_i, rd_req_i, rd_idx_i,
    input  rd_ack_o, rd_cnt_o, err_flags_o, err_any_o, err_total_o,
           first_vld_o, first_idx_o, first_ts_o, state_o
  );

  modport slave (
    input  err_pulse_i, arm_i, freeze_i, clr_i, rd_req_i, rd_idx_i,
    output rd_ack_o, rd_cnt_o, err_flags_o, err_any_o, err_total_o,
           first_vld_o, first_idx_o, first_ts_o, state_o
  );
endinterface

// File: rtl/cms_pix28_err_collector.sv
// Error collector: sticky per-index flags, saturating per-index and total
// counts, first-error capture with timestamp, and a req/ack count readout.
`timescale 1ns/1ps

// One error index: sticky flag plus saturating event counter.
module cms_pix28_err_lane #(
  parameter int CNT_W = 8
) (
  input  logic             clk,
  input  logic             reset_n,
  input  logic             rec_i,   // event on this index, already gated by ARMED
  input  logic             clr_i,
  output logic             flag_o,
  output logic [CNT_W-1:0] cnt_o
);
  logic             flag_q, flag_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;

  // Clear first, then apply this cycle's event so clr+event leaves cnt=1.
  always_comb begin
    flag_d = clr_i ? 1'b0 : flag_q;
    cnt_d  = clr_i ? '0   : cnt_q;
    if (rec_i) begin
      flag_d = 1'b1;
      if (cnt_d != {CNT_W{1'b1}}) cnt_d = cnt_d + CNT_W'(1);
    end
  end

  // Lane state registers.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      flag_q <= 1'b0;
      cnt_q  <= '0;
    end else begin
      flag_q <= flag_d;
      cnt_q  <= cnt_d;
    end
  end

  assign flag_o = flag_q;
  assign cnt_o  = cnt_q;
endmodule

module cms_pix28_err_collector #(
  parameter int NUM_IDX = 32,
  parameter int CNT_W   = 8,
  parameter int TOT_W   = 16,
  parameter int TS_W    = 32
) (
  input logic                        clk,
  input logic                        reset_n,
  cms_pix28_err_collector_if.slave   bus
);
  localparam int PC_W = $clog2(NUM_IDX + 1);

  typedef enum logic [1:0] {
    ST_DISARMED = 2'b00,
    ST_ARMED    = 2'b01,
    ST_FROZEN   = 2'b10
  } state_e;

  state_e                        state_q;
  logic                          armed;
  logic [NUM_IDX-1:0]            rec;
  logic [NUM_IDX-1:0]            flags;
  logic [NUM_IDX-1:0][CNT_W-1:0] cnt;

  logic [TS_W-1:0]  ts_q, ts_d;
  logic [TOT_W-1:0] total_q, total_d;
  logic [TOT_W:0]   tot_sum;
  logic [PC_W-1:0]  pcnt;
  logic             first_vld_q, first_vld_d;
  logic [4:0]       first_idx_q, first_idx_d;
  logic [TS_W-1:0]  first_ts_q, first_ts_d;
  logic [4:0]       low_idx;

  logic             rd_req_q, rd_req_d;
  logic             rd_pend_q, rd_pend_d;
  logic [4:0]       rd_idx_q, rd_idx_d;
  logic             rd_ack_q, rd_ack_d;
  logic [CNT_W-1:0] rd_cnt_q, rd_cnt_d;

  // Arm/freeze control; freeze beats arm while ARMED, arm beats freeze while
  // DISARMED, and re-arming from FROZEN keeps the collected counts.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_q <= ST_DISARMED;
    end else begin
      case (state_q)
        ST_DISARMED: if (bus.arm_i)    state_q <= ST_ARMED;
        ST_ARMED:    if (bus.freeze_i) state_q <= ST_FROZEN;
        ST_FROZEN:   if (bus.arm_i)    state_q <= ST_ARMED;
        default:                       state_q <= ST_DISARMED;
      endcase
    end
  end

  // Events count only when the current state is ARMED (so the freeze cycle
  // records and the arming cycle does not).
  assign armed = (state_q == ST_ARMED);
  assign rec   = armed ? bus.err_pulse_i : '0;

  for (genvar k = 0; k < NUM_IDX; k++) begin : g_lane
    cms_pix28_err_lane #(.CNT_W(CNT_W)) u_lane (
      .clk     (clk),
      .reset_n (reset_n),
      .rec_i   (rec[k]),
      .clr_i   (bus.clr_i),
      .flag_o  (flags[k]),
      .cnt_o   (cnt[k])
    );
  end

  // Timestamp, saturating total and first-error capture.
  always_comb begin
    ts_d = ts_q + TS_W'(1);

    pcnt = '0;
    for (int k = 0; k < NUM_IDX; k++) pcnt = pcnt + PC_W'(rec[k]);
    total_d = bus.clr_i ? '0 : total_q;
    tot_sum = {1'b0, total_d} + (TOT_W+1)'(pcnt);
    total_d = tot_sum[TOT_W] ? {TOT_W{1'b1}} : tot_sum[TOT_W-1:0];

    low_idx = '0;
    for (int k = NUM_IDX - 1; k >= 0; k--) if (rec[k]) low_idx = 5'(k);

    first_vld_d = bus.clr_i ? 1'b0 : first_vld_q;
    first_idx_d = bus.clr_i ? '0   : first_idx_q;
    first_ts_d  = bus.clr_i ? '0   : first_ts_q;
    if (!first_vld_d && (rec != '0)) begin
      first_vld_d = 1'b1;
      first_idx_d = low_idx;
      first_ts_d  = ts_q;
    end
  end

  // Readout: a rising request latches the index, the following edge issues
  // a single ack with the count as it stood before that edge.
  always_comb begin
    rd_req_d  = bus.rd_req_i;
    rd_pend_d = bus.rd_req_i & ~rd_req_q;
    rd_idx_d  = rd_pend_d ? bus.rd_idx_i : rd_idx_q;
    rd_ack_d  = rd_pend_q;
    rd_cnt_d  = rd_pend_q ? cnt[rd_idx_q] : '0;
  end

  // Collector and readout registers.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      ts_q        <= '0;
      total_q     <= '0;
      first_vld_q <= 1'b0;
      first_idx_q <= '0;
      first_ts_q  <= '0;
      rd_req_q    <= 1'b0;
      rd_pend_q   <= 1'b0;
      rd_idx_q    <= '0;
      rd_ack_q    <= 1'b0;
      rd_cnt_q    <= '0;
    end else begin
      ts_q        <= ts_d;
      total_q     <= total_d;
      first_vld_q <= first_vld_d;
      first_idx_q <= first_idx_d;
      first_ts_q  <= first_ts_d;
      rd_req_q    <= rd_req_d;
      rd_pend_q   <= rd_pend_d;
      rd_idx_q    <= rd_idx_d;
      rd_ack_q    <= rd_ack_d;
      rd_cnt_q    <= rd_cnt_d;
    end
  end

  assign bus.rd_ack_o    = rd_ack_q;
  assign bus.rd_cnt_o    = rd_cnt_q;
  assign bus.err_flags_o = flags;
  assign bus.err_any_o   = |flags;
  assign bus.err_total_o = total_q;
  assign bus.first_vld_o = first_vld_q;
  assign bus.first_idx_o = first_idx_q;
  assign bus.first_ts_o  = first_ts_q;
  assign bus.state_o     = state_q;
endmodule

// File: tb/tb_cms_pix28_err_collector.sv
// Directed bench for the error collector; a second TS_W=8 instance shares
// all stimulus to exercise timestamp wrap.
`timescale 1ns/1ps
module tb_cms_pix28_err_collector;
  localparam int CNT_W = 8;

  logic clk = 1'b0;
  logic reset_n = 1'b0;
  int   vectors = 0;
  int   miscompares = 0;
  int   cyc = 0;

  always #5 clk = ~clk;

  cms_pix28_err_collector_if #(.TS_W(32)) b ();
  cms_pix28_err_collector_if #(.TS_W(8))  b8 ();

  cms_pix28_err_collector #(.TS_W(32)) dut (.clk(clk), .reset_n(reset_n), .bus(b));
  cms_pix28_err_collector #(.TS_W(8))  dut8 (.clk(clk), .reset_n(reset_n), .bus(b8));

  assign b8.err_pulse_i = b.err_pulse_i;
  assign b8.arm_i       = b.arm_i;
  assign b8.freeze_i    = b.freeze_i;
  assign b8.clr_i       = b.clr_i;
  assign b8.rd_req_i    = b.rd_req_i;
  assign b8.rd_idx_i    = b.rd_idx_i;

  task automatic tick();
    @(posedge clk);
    cyc++;
    @(negedge clk);
  endtask

  task automatic idle_inputs();
    b.err_pulse_i = '0; b.arm_i = 1'b0; b.freeze_i = 1'b0;
    b.clr_i = 1'b0; b.rd_req_i = 1'b0; b.rd_idx_i = '0;
  endtask

  task automatic do_reset();
    reset_n = 1'b0;
    idle_inputs();
    repeat (2) @(posedge clk);
    @(negedge clk);
    reset_n = 1'b1;
    cyc = 0;
  endtask

  // Hold a request for 'hold' cycles then drop it for one; count acks seen.
  task automatic do_read(input logic [4:0] idx, input int hold, output int acks,
                         output logic [CNT_W-1:0] val);
    acks = 0; val = '0;
    b.rd_idx_i = idx; b.rd_req_i = 1'b1;
    for (int i = 0; i < hold; i++) begin
      tick();
      if (b.rd_ack_o) begin acks++; val = b.rd_cnt_o; end
    end
    b.rd_req_i = 1'b0;
    tick();
    if (b.rd_ack_o) acks++;
  endtask

  task automatic test_reset();
    idle_inputs();
    @(negedge clk);
    vectors++; if (b.state_o !== 2'b00) begin miscompares++; $display("FAIL rst_state: got %b want 00", b.state_o); end
    vectors++; if (b.err_flags_o !== 32'h0) begin miscompares++; $display("FAIL rst_flags: got %h want 0", b.err_flags_o); end
    vectors++; if (b.err_any_o !== 1'b0) begin miscompares++; $display("FAIL rst_any: got %b want 0", b.err_any_o); end
    vectors++; if (b.err_total_o !== 16'd0) begin miscompares++; $display("FAIL rst_total: got %0d want 0", b.err_total_o); end
    vectors++; if ({b.first_vld_o, b.first_idx_o, b.first_ts_o} !== 38'd0) begin miscompares++; $display("FAIL rst_first: got %b/%0d/%0d want 0", b.first_vld_o, b.first_idx_o, b.first_ts_o); end
    vectors++; if ({b.rd_ack_o, b.rd_cnt_o} !== 9'd0) begin miscompares++; $display("FAIL rst_rd: got %b/%0d want 0", b.rd_ack_o, b.rd_cnt_o); end
    do_reset();
  endtask

  task automatic test_first_error();
    int acks; logic [CNT_W-1:0] v; int t0;
    b.arm_i = 1'b1; tick(); b.arm_i = 1'b0;
    vectors++; if (b.state_o !== 2'b01) begin miscompares++; $display("FAIL arm_state: got %b want 01", b.state_o); end
    t0 = cyc;
    b.err_pulse_i = 32'h0001_0008; tick(); b.err_pulse_i = '0;
    vectors++; if (b.err_flags_o !== 32'h0001_0008) begin miscompares++; $display("FAIL first_flags: got %h want 00010008", b.err_flags_o); end
    vectors++; if (b.err_any_o !== 1'b1) begin miscompares++; $display("FAIL first_any: got %b want 1", b.err_any_o); end
    vectors++; if (b.err_total_o !== 16'd2) begin miscompares++; $display("FAIL first_total: got %0d want 2", b.err_total_o); end
    vectors++; if (b.first_vld_o !== 1'b1 || b.first_idx_o !== 5'd3) begin miscompares++; $display("FAIL first_idx: got %b/%0d want 1/3", b.first_vld_o, b.first_idx_o); end
    vectors++; if (b.first_ts_o !== 32'(t0)) begin miscompares++; $display("FAIL first_ts: got %0d want %0d", b.first_ts_o, t0); end
    do_read(5'd16, 2, acks, v);
    vectors++; if (acks !== 1 || v !== 8'd1) begin miscompares++; $display("FAIL read16: got acks=%0d cnt=%0d want 1/1", acks, v); end
  endtask

  task automatic test_count_saturation();
    int acks; logic [CNT_W-1:0] v;
    b.clr_i = 1'b1; tick(); b.clr_i = 1'b0;
    vectors++; if (b.err_total_o !== 16'd0 || b.first_vld_o !== 1'b0) begin miscompares++; $display("FAIL clr_only: got total=%0d vld=%b want 0/0", b.err_total_o, b.first_vld_o); end
    b.err_pulse_i = 32'h0000_0100;
    for (int i = 0; i < 300; i++) tick();
    b.err_pulse_i = '0;
    vectors++; if (b.err_total_o !== 16'd300) begin miscompares++; $display("FAIL sat_total: got %0d want 300", b.err_total_o); end
    vectors++; if (b.err_flags_o !== 32'h0000_0100 || b.first_idx_o !== 5'd8) begin miscompares++; $display("FAIL sat_flags: got %h/%0d want 00000100/8", b.err_flags_o, b.first_idx_o); end
    do_read(5'd8, 2, acks, v);
    vectors++; if (acks !== 1 || v !== 8'd255) begin miscompares++; $display("FAIL sat_cnt8: got acks=%0d cnt=%0d want 1/255", acks, v); end
  endtask

  task automatic test_gating();
    int acks; logic [CNT_W-1:0] v;
    do_reset();
    b.err_pulse_i = 32'h400; tick(); b.err_pulse_i = '0;
    vectors++; if (b.err_flags_o !== 32'h0 || b.err_total_o !== 16'd0) begin miscompares++; $display("FAIL disarmed_ev: got %h/%0d want 0/0", b.err_flags_o, b.err_total_o); end
    b.arm_i = 1'b1; b.freeze_i = 1'b1; tick();
    vectors++; if (b.state_o !== 2'b01) begin miscompares++; $display("FAIL arm_wins: got %b want 01", b.state_o); end
    tick();
    vectors++; if (b.state_o !== 2'b10) begin miscompares++; $display("FAIL freeze_wins: got %b want 10", b.state_o); end
    b.arm_i = 1'b0; b.freeze_i = 1'b0;
    b.err_pulse_i = 32'h400; tick();
    vectors++; if (b.err_flags_o !== 32'h0 || b.err_total_o !== 16'd0) begin miscompares++; $display("FAIL frozen_ev: got %h/%0d want 0/0", b.err_flags_o, b.err_total_o); end
    b.arm_i = 1'b1; tick(); b.arm_i = 1'b0;
    vectors++; if (b.err_flags_o !== 32'h0 || b.state_o !== 2'b01) begin miscompares++; $display("FAIL arming_cycle: got %h/%b want 0/01", b.err_flags_o, b.state_o); end
    tick(); b.err_pulse_i = '0;
    vectors++; if (b.err_flags_o !== 32'h400) begin miscompares++; $display("FAIL rearm_flag: got %h want 00000400", b.err_flags_o); end
    do_read(5'd10, 2, acks, v);
    vectors++; if (acks !== 1 || v !== 8'd1) begin miscompares++; $display("FAIL rearm_cnt: got acks=%0d cnt=%0d want 1/1", acks, v); end
    b.freeze_i = 1'b1; b.err_pulse_i = 32'h400; tick();
    b.freeze_i = 1'b0; b.err_pulse_i = '0;
    do_read(5'd10, 2, acks, v);
    vectors++; if (v !== 8'd2 || b.state_o !== 2'b10) begin miscompares++; $display("FAIL freeze_cycle: got cnt=%0d st=%b want 2/10", v, b.state_o); end
  endtask

  task automatic test_clr_with_event();
    int acks; logic [CNT_W-1:0] v; int t0;
    b.arm_i = 1'b1; tick(); b.arm_i = 1'b0;
    do_read(5'd10, 2, acks, v);
    vectors++; if (v !== 8'd2) begin miscompares++; $display("FAIL rearm_keep: got %0d want 2", v); end
    t0 = cyc;
    b.clr_i = 1'b1; b.err_pulse_i = 32'h0008_0000; tick();
    b.clr_i = 1'b0; b.err_pulse_i = '0;
    vectors++; if (b.err_flags_o !== 32'h0008_0000 || b.err_total_o !== 16'd1) begin miscompares++; $display("FAIL clr_ev: got %h/%0d want 00080000/1", b.err_flags_o, b.err_total_o); end
    vectors++; if (b.first_idx_o !== 5'd19 || b.first_ts_o !== 32'(t0)) begin miscompares++; $display("FAIL clr_first: got %0d/%0d want 19/%0d", b.first_idx_o, b.first_ts_o, t0); end
    do_read(5'd10, 2, acks, v);
    vectors++; if (v !== 8'd0) begin miscompares++; $display("FAIL clr_cnt10: got %0d want 0", v); end
    do_read(5'd19, 2, acks, v);
    vectors++; if (v !== 8'd1) begin miscompares++; $display("FAIL clr_cnt19: got %0d want 1", v); end
  endtask

  task automatic test_readout_handshake();
    int acks; logic [CNT_W-1:0] v;
    do_read(5'd19, 5, acks, v);
    vectors++; if (acks !== 1 || v !== 8'd1) begin miscompares++; $display("FAIL hold5: got acks=%0d cnt=%0d want 1/1", acks, v); end
    b.rd_idx_i = 5'd19; b.rd_req_i = 1'b1; tick();
    reset_n = 1'b0; #1;
    vectors++; if ({b.rd_ack_o, b.rd_cnt_o, b.err_flags_o, b.err_total_o, b.state_o, b.first_vld_o} !== '0) begin miscompares++; $display("FAIL midrd_rst: got ack=%b flags=%h total=%0d st=%b", b.rd_ack_o, b.err_flags_o, b.err_total_o, b.state_o); end
    b.rd_req_i = 1'b0;
    tick();
    reset_n = 1'b1; cyc = 0; acks = 0;
    for (int i = 0; i < 3; i++) begin tick(); if (b.rd_ack_o) acks++; end
    vectors++; if (acks !== 0) begin miscompares++; $display("FAIL midrd_ack: got %0d acks want 0", acks); end
  endtask

  task automatic test_total_saturation();
    int acks; logic [CNT_W-1:0] v; logic [15:0] prev; int wraps;
    b.arm_i = 1'b1; tick(); b.arm_i = 1'b0;
    b.err_pulse_i = '1; prev = '0; wraps = 0;
    for (int i = 1; i <= 2100; i++) begin
      tick();
      if (b.err_total_o < prev) wraps++;
      prev = b.err_total_o;
      if (i == 2047) begin
        vectors++; if (b.err_total_o !== 16'd65504) begin miscompares++; $display("FAIL tot_2047: got %0d want 65504", b.err_total_o); end
      end
      if (i == 2048) begin
        vectors++; if (b.err_total_o !== 16'd65535) begin miscompares++; $display("FAIL tot_2048: got %0d want 65535", b.err_total_o); end
      end
    end
    b.err_pulse_i = '0;
    vectors++; if (b.err_total_o !== 16'd65535 || wraps !== 0) begin miscompares++; $display("FAIL tot_end: got %0d wraps=%0d want 65535/0", b.err_total_o, wraps); end
    vectors++; if (b.err_flags_o !== 32'hFFFF_FFFF || b.first_idx_o !== 5'd0) begin miscompares++; $display("FAIL all_flags: got %h/%0d want ffffffff/0", b.err_flags_o, b.first_idx_o); end
    do_read(5'd31, 2, acks, v);
    vectors++; if (v !== 8'd255) begin miscompares++; $display("FAIL cnt31: got %0d want 255", v); end
  endtask

  task automatic test_ts_wrap();
    logic [7:0] exp8;
    do_reset();
    b.arm_i = 1'b1; tick(); b.arm_i = 1'b0;
    for (int i = 0; i < 400 && cyc < 260; i++) tick();
    exp8 = 8'(cyc);
    b.err_pulse_i = 32'h20; tick(); b.err_pulse_i = '0;
    vectors++; if (b8.first_ts_o !== exp8 || exp8 !== 8'd4) begin miscompares++; $display("FAIL ts8_wrap: got %0d want 4", b8.first_ts_o); end
    vectors++; if (b.first_ts_o !== 32'd260 || b8.first_idx_o !== 5'd5) begin miscompares++; $display("FAIL ts32: got %0d/%0d want 260/5", b.first_ts_o, b8.first_idx_o); end
  endtask

  initial begin
    test_reset();
    test_first_error();
    test_count_saturation();
    test_gating();
    test_clr_with_event();
    test_readout_handshake();
    test_total_saturation();
    test_ts_wrap();
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end
endmodule
